// File: rtl/wrr_arbiter_if.sv
// Handshake bundle between N requesting masters and the weighted round-robin
// arbiter. The lock signal exists only when WRR_LOCK_EN is defined.
interface wrr_arbiter_if #(
    parameter int N  = 8,
    parameter int WW = 4
);
    localparam int IW = $clog2(N);

    logic [N-1:0]    req;
    logic [N*WW-1:0] weight;
    logic            done;
    logic [N-1:0]    gnt;
    logic            gnt_vld;
    logic [IW-1:0]   gnt_idx;
`ifdef WRR_LOCK_EN
    logic            lock;
`endif

    // Requestor side: raises requests, supplies weights, signals completion.
    modport master (
`ifdef WRR_LOCK_EN
        output lock,
`endif
        output req, weight, done,
        input  gnt, gnt_vld, gnt_idx
    );

    // Arbiter side.
    modport slave (
`ifdef WRR_LOCK_EN
        input  lock,
`endif
        input  req, weight, done,
        output gnt, gnt_vld, gnt_idx
    );
endinterface

// File: rtl/wrr_arbiter.sv
// wrr_arbiter: N-requestor weighted round-robin arbiter with registered one-hot
// grant. The owner keeps the grant for up to weight[i] done pulses (zero weight
// counts as one), then rotation advances from the owner. Release and re-grant
// happen on the same edge, so back-to-back grants have no idle bubble.
// Optional feature macro: WRR_LOCK_EN (adds bus.lock to hold the grant).
module wrr_arbiter #(
    parameter int N  = 8,
    parameter int WW = 4
) (
    input logic          clk,
    input logic          rst_n,
    wrr_arbiter_if.slave bus
);
    localparam int IW = $clog2(N);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [WW-1:0]   credit;
    logic [N-1:0]    gnt_q;
    logic            gnt_vld_q;
    logic [IW-1:0]   gnt_idx_q;

    logic [WW-1:0]   w_arr [N];
    logic [IW-1:0]   base;
    logic [IW-1:0]   cand;
    int unsigned     scan_pos;
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [N-1:0]    win_onehot;
    logic [WW-1:0]   win_credit;
    logic            lock_hold;
    logic            release_now;

    for (genvar g = 0; g < N; g++) begin : g_weight
        assign w_arr[g] = bus.weight[g*WW +: WW];
    end

`ifdef WRR_LOCK_EN
    assign lock_hold = bus.lock;
`else
    assign lock_hold = 1'b0;
`endif

    // While busy, a release rescans from the owner so it is only reachable by wrap.
    assign base = (state == S_BUSY) ? gnt_idx_q : ptr;

    // Owner gives up on dropped request (lock ignored) or on its last credit.
    assign release_now = !bus.req[gnt_idx_q]
                       || (bus.done && (credit == WW'(1)) && !lock_hold);

    // Round-robin winner search starting just after base, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_pos  = 0;
        cand      = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            scan_pos = 32'(base) + k;
            if (scan_pos >= N) begin
                scan_pos = scan_pos - N;
            end
            cand = IW'(scan_pos);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Grant vector and credit load for the current winner; zero weight acts as one.
    always_comb begin
        win_onehot          = '0;
        win_onehot[win_idx] = 1'b1;
        win_credit          = (w_arr[win_idx] == '0) ? WW'(1) : w_arr[win_idx];
    end

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= IW'(N - 1);
            credit    <= '0;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            gnt_idx_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        state     <= S_BUSY;
                        gnt_q     <= win_onehot;
                        gnt_vld_q <= 1'b1;
                        gnt_idx_q <= win_idx;
                        credit    <= win_credit;
                    end
                end
                S_BUSY: begin
                    if (release_now) begin
                        ptr <= gnt_idx_q;
                        if (win_found) begin
                            gnt_q     <= win_onehot;
                            gnt_idx_q <= win_idx;
                            credit    <= win_credit;
                        end else begin
                            state     <= S_IDLE;
                            gnt_q     <= '0;
                            gnt_vld_q <= 1'b0;
                            gnt_idx_q <= '0;
                            credit    <= '0;
                        end
                    end else if (bus.done && (credit > WW'(1))) begin
                        // Under lock the credit saturates at one instead of releasing.
                        credit <= credit - WW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_vld = gnt_vld_q;
    assign bus.gnt_idx = gnt_idx_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter (N=8, WW=4): directed scenarios with fixed
// expected grant patterns, then randomized traffic against a transaction-level
// model of owner, remaining credit and rotation point.
module tb_wrr_arbiter;
    localparam int N  = 8;
    localparam int WW = 4;

    logic clk;
    logic rst_n;

    wrr_arbiter_if #(.N(N), .WW(WW)) bus ();

    wrr_arbiter #(.N(N), .WW(WW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    bit m_busy;
    int m_owner;
    int m_credit;
    int m_ptr;
    bit lock_v;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_lock(input bit v);
        lock_v = v;
`ifdef WRR_LOCK_EN
        bus.lock = v;
`endif
    endtask

    function automatic int eff_weight(input int i);
        int w;
        w = int'((bus.weight >> (i * WW)) & ((1 << WW) - 1));
        return (w == 0) ? 1 : w;
    endfunction

    // First requester after position 'after', wrapping; -1 if none.
    function automatic int pick(input int after);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (after + k) % N;
            if (bus.req[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy   = 0;
        m_owner  = 0;
        m_credit = 0;
        m_ptr    = N - 1;
    endtask

    task automatic model_grant(input int w);
        if (w < 0) begin
            m_busy   = 0;
            m_owner  = 0;
            m_credit = 0;
        end else begin
            m_busy   = 1;
            m_owner  = w;
            m_credit = eff_weight(w);
        end
    endtask

    // Advance the model with the inputs present just before the clock edge.
    task automatic model_step();
        if (!m_busy) begin
            if (bus.req != '0) model_grant(pick(m_ptr));
        end else if (!bus.req[m_owner] || (bus.done && m_credit == 1 && !lock_v)) begin
            m_ptr = m_owner;
            model_grant(pick(m_owner));
        end else if (bus.done && m_credit > 1) begin
            m_credit--;
        end
    endtask

    task automatic compare_model(input string tag);
        logic [N-1:0] eg;
        eg = m_busy ? (N'(1) << m_owner) : '0;
        check({tag, ".gnt"}, 64'(bus.gnt), 64'(eg));
        check({tag, ".vld"}, 64'(bus.gnt_vld), 64'(m_busy));
        check({tag, ".idx"}, 64'(bus.gnt_idx), 64'(m_busy ? m_owner : 0));
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst.gnt", 64'(bus.gnt), 64'h0);
        check("rst.vld", 64'(bus.gnt_vld), 64'h0);
        check("rst.idx", 64'(bus.gnt_idx), 64'h0);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] pat3 [8];
        rst_n      = 1'b1;
        bus.req    = '0;
        bus.done   = 1'b0;
        bus.weight = {N{4'd1}};
        set_lock(1'b0);
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Idle with no request, then first grant one cycle after req.
        cycle("idle");
        check("t1.idle", 64'(bus.gnt), 64'h00);
        bus.req = 8'h01;
        cycle("t1");
        check("t1.gnt", 64'(bus.gnt), 64'h01);

        // All weights 1, every requestor, done each cycle: strict rotation.
        do_reset();
        bus.weight = {N{4'd1}};
        bus.req    = 8'hFF;
        bus.done   = 1'b1;
        for (int k = 0; k <= N; k++) begin
            cycle("t2");
            check("t2.order", 64'(bus.gnt), 64'(8'h01 << (k % N)));
        end

        // w0=3, w1=1.
        do_reset();
        bus.weight = {N{4'd1}};
        bus.weight[3:0] = 4'd3;
        bus.weight[7:4] = 4'd1;
        bus.req  = 8'h03;
        bus.done = 1'b1;
        pat3 = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h01, 8'h01, 8'h02};
        for (int k = 0; k < 8; k++) begin
            cycle("t3");
            check("t3.pat", 64'(bus.gnt), 64'(pat3[k]));
        end

        // Zero weight behaves as one credit.
        do_reset();
        bus.weight = {N{4'd2}};
        bus.weight[11:8] = 4'd0;
        bus.req  = 8'h04;
        bus.done = 1'b0;
        cycle("t4");
        check("t4.gnt", 64'(bus.gnt), 64'h04);
        bus.req  = 8'h0C;
        bus.done = 1'b1;
        cycle("t4");
        check("t4.rel", 64'(bus.gnt), 64'h08);

        // Owner 5 abandons without done; 6 takes over next cycle.
        do_reset();
        bus.done = 1'b0;
        bus.req  = 8'h60;
        cycle("t5");
        check("t5.own", 64'(bus.gnt), 64'h20);
        bus.req = 8'h40;
        cycle("t5");
        check("t5.move", 64'(bus.gnt), 64'h40);
        check("t5.idx", 64'(bus.gnt_idx), 64'd6);

        // Asynchronous reset while busy.
        do_reset();
        bus.req = 8'h10;
        cycle("t6");
        check("t6.own", 64'(bus.gnt), 64'h10);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6.async", 64'(bus.gnt), 64'h00);
        check("t6.vld", 64'(bus.gnt_vld), 64'h0);
        #2;
        rst_n = 1'b1;
        bus.req = 8'hFF;
        cycle("t6");
        check("t6.restart", 64'(bus.gnt), 64'h01);

`ifdef WRR_LOCK_EN
        // Lock holds the grant past its credit; release on unlocked done.
        do_reset();
        bus.weight = {N{4'd1}};
        bus.req  = 8'h02;
        bus.done = 1'b0;
        set_lock(1'b1);
        cycle("t7");
        bus.req  = 8'h06;
        bus.done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle("t7");
            check("t7.hold", 64'(bus.gnt), 64'h02);
        end
        set_lock(1'b0);
        cycle("t7");
        check("t7.rot", 64'(bus.gnt), 64'h04);
`endif

        // Randomized traffic against the model.
        do_reset();
        bus.done = 1'b0;
        bus.req  = '0;
        set_lock(1'b0);
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) bus.weight = {$urandom, $urandom};
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) bus.req[i] = ~bus.req[i];
            end
            bus.done = ($urandom_range(0, 2) != 0);
`ifdef WRR_LOCK_EN
            set_lock($urandom_range(0, 3) == 0);
`endif
            cycle("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
